m_dmem_resp: RTL and testbench

//  Data-memory responder for the pipelined core's load/store port: the memory side
//  of the request/response handshake the core drives with address, write-enable,

---
 rtl/m_dmem_defs.sv | 19 +
 rtl/m_dmem_array.sv | 36 +++
 rtl/m_dmem_resp.sv | 139 +++++++++++++
 tb/tb_m_dmem_resp.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/m_dmem_defs.sv
// Shared definitions for the data-memory responder: FSM encodings, default
// geometry/latency and the byte-strobe width.
package m_dmem_defs;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int DMEM_LAT_DEF        = 2;
    localparam int DMEM_DEPTH_LOG2_DEF = 12;
    localparam int DATA_W              = 32;
    localparam int BE_W                = 4;

    // A word access is misaligned when either of the two byte-offset bits is set.
    function automatic logic addr_misaligned(input logic [DATA_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/m_dmem_array.sv
// Single-port word RAM, 2**DEPTH_LOG2 words, byte-enabled synchronous write and
// registered read. Each byte lane is its own array so it maps onto block RAM.
module m_dmem_array
    import m_dmem_defs::*;
#(
    parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2_DEF
) (
    input  logic                  w_clk,
    input  logic                  w_en,
    input  logic                  w_we,
    input  logic [BE_W-1:0]       w_be,
    input  logic [DEPTH_LOG2-1:0] w_addr,
    input  logic [DATA_W-1:0]     w_wdata,
    output logic [DATA_W-1:0]     w_rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] mem [0:(1 << DEPTH_LOG2)-1];
            logic [7:0] rd_lane_reg;

            always_ff @(posedge w_clk) begin
                if (w_en) begin
                    if (w_we && w_be[gi]) begin
                        mem[w_addr] <= w_wdata[gi*8 +: 8];
                    end
                    rd_lane_reg <= mem[w_addr];
                end
            end

            assign w_rdata[gi*8 +: 8] = rd_lane_reg;
        end
    endgenerate

endmodule

// File: rtl/m_dmem_resp.sv
// Fixed-latency data-memory responder, one request in flight.
// Optional misalignment error check enabled by defining DMEM_MISALIGN_CHK_EN.
module m_dmem_resp
    import m_dmem_defs::*;
#(
    parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2_DEF,
    parameter int LAT        = DMEM_LAT_DEF
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic [DATA_W-1:0] w_req_addr,
    input  logic              w_req_we,
    input  logic [DATA_W-1:0] w_req_wdata,
    input  logic [BE_W-1:0]   w_req_be,
    output logic              w_rsp_valid,
    input  logic              w_rsp_ready,
    output logic [DATA_W-1:0] w_rsp_rdata,
    output logic              w_rsp_err
);

    localparam int CNT_W = $clog2(LAT + 2) + 1;

    logic [1:0]            state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [DATA_W-1:0]     rdata_reg;
    logic                  err_reg;
    logic [DEPTH_LOG2-1:0] idx_reg;
    logic                  we_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [BE_W-1:0]       be_reg;
    logic                  req_mis;
    logic                  mis_reg;
    logic                  accept;

    logic                  ram_en;
    logic                  ram_we;
    logic [BE_W-1:0]       ram_be;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_q;
    logic                  unused_addr_bits;

    assign w_req_ready = w_rst_n && (state_reg == ST_IDLE);
    assign accept      = w_req_ready && w_req_valid;
    assign w_rsp_valid = (state_reg == ST_RESP);
    assign w_rsp_rdata = rdata_reg;
    assign w_rsp_err   = err_reg;

    assign unused_addr_bits = ^{w_req_addr[DATA_W-1:DEPTH_LOG2+2], w_req_addr[1:0]};

`ifdef DMEM_MISALIGN_CHK_EN
    assign req_mis = addr_misaligned(w_req_addr);

    always_ff @(posedge w_clk) begin
        if (accept) begin
            mis_reg <= req_mis;
        end
    end
`else
    assign req_mis = 1'b0;
    assign mis_reg = 1'b0;
`endif

    always_ff @(posedge w_clk) begin
        if (accept) begin
            idx_reg   <= w_req_addr[DEPTH_LOG2+1:2];
            we_reg    <= w_req_we;
            wdata_reg <= w_req_wdata;
            be_reg    <= w_req_be;
        end
    end

    // The RAM is touched one edge before the response so its registered read
    // lands in the response register exactly LAT edges after accept.
    generate
        if (LAT == 1) begin : g_issue_at_accept
            assign ram_en    = accept;
            assign ram_we    = w_req_we && !req_mis;
            assign ram_be    = w_req_be;
            assign ram_idx   = w_req_addr[DEPTH_LOG2+1:2];
            assign ram_wdata = w_req_wdata;
        end else begin : g_issue_in_busy
            assign ram_en    = (state_reg == ST_BUSY) && (cnt_reg == CNT_W'(2));
            assign ram_we    = we_reg && !mis_reg;
            assign ram_be    = be_reg;
            assign ram_idx   = idx_reg;
            assign ram_wdata = wdata_reg;
        end
    endgenerate

    m_dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .w_clk   (w_clk),
        .w_en    (ram_en),
        .w_we    (ram_we),
        .w_be    (ram_be),
        .w_addr  (ram_idx),
        .w_wdata (ram_wdata),
        .w_rdata (ram_q)
    );

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (w_req_valid) begin
                        state_reg <= ST_BUSY;
                        cnt_reg   <= CNT_W'(LAT);
                    end
                end
                ST_BUSY: begin
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= ST_RESP;
                        cnt_reg   <= '0;
                        rdata_reg <= (we_reg || mis_reg) ? '0 : ram_q;
                        err_reg   <= mis_reg;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (w_rsp_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_dmem_resp.sv
// Directed bench for m_dmem_resp: scoreboard of expected responses, latency,
// backpressure, byte strobes, address wrap and reset during an access.
module tb_m_dmem_resp;
    import m_dmem_defs::*;

    localparam int DL2  = 12;
    localparam int LATP = 2;

    logic        w_clk;
    logic        w_rst_n;
    logic        w_req_valid;
    logic        w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_req_we;
    logic [31:0] w_req_wdata;
    logic [3:0]  w_req_be;
    logic        w_rsp_valid;
    logic        w_rsp_ready;
    logic [31:0] w_rsp_rdata;
    logic        w_rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [int];
    int          n_vec = 0;
    int          n_err = 0;

    m_dmem_resp #(
        .DEPTH_LOG2 (DL2),
        .LAT        (LATP)
    ) dut (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .w_req_valid (w_req_valid),
        .w_req_ready (w_req_ready),
        .w_req_addr  (w_req_addr),
        .w_req_we    (w_req_we),
        .w_req_wdata (w_req_wdata),
        .w_req_be    (w_req_be),
        .w_rsp_valid (w_rsp_valid),
        .w_rsp_ready (w_rsp_ready),
        .w_rsp_rdata (w_rsp_rdata),
        .w_rsp_err   (w_rsp_err)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_mis(input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // One request/response; called at posedge+1. hold = cycles of rsp backpressure.
    task automatic txn(input string tag, input logic [31:0] a, input logic we,
                       input logic [31:0] wd, input logic [3:0] be, input int hold);
        exp_t        e;
        exp_t        got;
        int          idx;
        int          cyc;
        logic [31:0] w;
        logic [31:0] r0;
        logic        e0;

        idx = int'(a[DL2+1:2]);
        chk({tag, "/req_ready"}, 32'(w_req_ready), 32'd1);
        w_req_valid = 1'b1;
        w_req_addr  = a;
        w_req_we    = we;
        w_req_wdata = wd;
        w_req_be    = be;
        @(posedge w_clk);
        #1;
        w_req_valid = 1'b0;
        w_req_addr  = $urandom;
        w_req_wdata = $urandom;

        e.err = exp_mis(a);
        if (we) begin
            e.rdata = 32'h0;
            if (!e.err) begin
                w = model.exists(idx) ? model[idx] : 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
                end
                model[idx] = w;
            end
        end else begin
            e.rdata = e.err ? 32'h0 : model[idx];
        end
        sb.push_back(e);

        cyc = 0;
        while (w_rsp_valid !== 1'b1 && cyc < 20) begin
            @(posedge w_clk);
            #1;
            cyc++;
        end
        chk({tag, "/latency"}, 32'(cyc), 32'(LATP));

        r0 = w_rsp_rdata;
        e0 = w_rsp_err;
        for (int h = 0; h < hold; h++) begin
            w_req_valid = 1'b1;
            w_req_we    = 1'b1;
            w_req_addr  = a;
            w_req_wdata = 32'h0BAD_0BAD;
            w_req_be    = 4'hF;
            @(posedge w_clk);
            #1;
            chk({tag, "/bp_valid"}, 32'(w_rsp_valid), 32'd1);
            chk({tag, "/bp_ready"}, 32'(w_req_ready), 32'd0);
            chk({tag, "/bp_rdata"}, w_rsp_rdata, r0);
            chk({tag, "/bp_err"},   32'(w_rsp_err), 32'(e0));
        end
        w_req_valid = 1'b0;

        got = sb.pop_front();
        chk({tag, "/rdata"}, w_rsp_rdata, got.rdata);
        chk({tag, "/err"},   32'(w_rsp_err), 32'(got.err));

        w_rsp_ready = 1'b1;
        @(posedge w_clk);
        #1;
        w_rsp_ready = 1'b0;
        chk({tag, "/valid_clr"}, 32'(w_rsp_valid), 32'd0);
        $display("txn %s addr=%h we=%0d be=%h rdata=%h err=%0d", tag, a, we, be,
                 got.rdata, got.err);
    endtask

    initial begin
        w_rst_n     = 1'b0;
        w_req_valid = 1'b0;
        w_req_addr  = '0;
        w_req_we    = 1'b0;
        w_req_wdata = '0;
        w_req_be    = '0;
        w_rsp_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge w_clk);
            #1;
            w_req_valid = 1'b1;
            chk("rst/req_ready", 32'(w_req_ready), 32'd0);
            chk("rst/rsp_valid", 32'(w_rsp_valid), 32'd0);
            chk("rst/rdata",     w_rsp_rdata, 32'h0);
            chk("rst/err",       32'(w_rsp_err), 32'd0);
        end
        w_req_valid = 1'b0;
        w_rst_n     = 1'b1;
        #1;
        chk("rst/ready_after", 32'(w_req_ready), 32'd1);
        $display("txn reset released");

        // Write then read
        txn("st10", 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0);
        txn("ld10", 32'h0000_0010, 1'b0, 32'h0, 4'h0, 0);

        // Byte strobe and address wrap
        txn("st14", 32'h0000_0014, 1'b1, 32'h1122_3344, 4'hF, 0);
        txn("st14b", 32'h0000_0014, 1'b1, 32'h0000_AA00, 4'b0010, 0);
        txn("ld14", 32'h0000_0014, 1'b0, 32'h0, 4'h0, 0);
        chk("ld14/model", model[5], 32'h1122_AA44);
        txn("ldwrap", (32'd4 << DL2) + 32'h10, 1'b0, 32'h0, 4'h0, 0);

        // Backpressure: stores attempted while held must not be accepted
        txn("st40", 32'h0000_0040, 1'b1, 32'hCAFE_F00D, 4'hF, 0);
        txn("ld40bp", 32'h0000_0040, 1'b0, 32'h0, 4'h0, 5);
        txn("ld40", 32'h0000_0040, 1'b0, 32'h0, 4'h0, 0);
        txn("st44bp", 32'h0000_0044, 1'b1, 32'h1357_9BDF, 4'hF, 5);

        // Reset during BUSY discards the pending store
        txn("st20", 32'h0000_0020, 1'b1, 32'h1111_1111, 4'hF, 0);
        w_req_valid = 1'b1;
        w_req_addr  = 32'h0000_0020;
        w_req_we    = 1'b1;
        w_req_wdata = 32'h0000_0055;
        w_req_be    = 4'hF;
        @(posedge w_clk);
        #1;
        w_req_valid = 1'b0;
        chk("rstmid/busy_ready", 32'(w_req_ready), 32'd0);
        w_rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            @(posedge w_clk);
            #1;
            chk("rstmid/rsp_valid", 32'(w_rsp_valid), 32'd0);
            chk("rstmid/req_ready", 32'(w_req_ready), 32'd0);
        end
        w_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge w_clk);
            #1;
            chk("rstmid/no_rsp", 32'(w_rsp_valid), 32'd0);
        end
        chk("rstmid/ready", 32'(w_req_ready), 32'd1);
        $display("txn reset mid-op discarded store to 0x20");
        txn("ld20", 32'h0000_0020, 1'b0, 32'h0, 4'h0, 0);

        // Misaligned store: error when checked, otherwise writes the enclosing word
        txn("st22", 32'h0000_0022, 1'b1, 32'hA5A5_5A5A, 4'hF, 0);
        txn("ld20b", 32'h0000_0020, 1'b0, 32'h0, 4'h0, 0);
        txn("ld23", 32'h0000_0023, 1'b0, 32'h0, 4'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
